// File: rtl/dm_ctrl.sv
// dm_ctrl: load/store sequencer between the memory stage and the word-wide data memory.
// Handles alignment errors, lane selection, load extension and sub-word read-modify-write.
module dm_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [9:0]  dm_addr,
    output logic [3:0]  dm_BE,
    output logic [31:0] dm_din,
    output logic        dm_DMWr,
    input  logic [31:0] dm_dout
);

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 10;
    localparam int unsigned BW = 4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_EXT,
        S_MRG,
        S_WR
    } state_t;

    state_t state, state_nx;

    logic          we_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic [1:0]    off_q;
    logic [DW-1:0] wdata_q;

    logic          bad_c;
    logic          done_nx;
    logic          err_nx;
    logic [DW-1:0] rdata_nx;
    logic [BW-1:0] lane_mask_c;
    logic [DW-1:0] lane_bits_c;
    logic [DW-1:0] wdata_rep_c;
    logic [DW-1:0] merged_c;
    logic [7:0]    byte_c;
    logic [15:0]   half_c;
    logic [DW-1:0] load_ext_c;
    logic          unused_addr_c;

    // Upper address bits fall outside the 4 KiB memory and are intentionally dropped.
    assign unused_addr_c = ^addr[31:12];

    // Misaligned halfword/word or reserved size is rejected before touching memory.
    assign bad_c = (size == SZ_RSVD)
                 | ((size == SZ_HALF) & addr[0])
                 | ((size == SZ_WORD) & (|addr[1:0]));

    // Lane decode, load extension and store merge from the latched request.
    always_comb begin
        lane_mask_c = 4'b1111;
        wdata_rep_c = wdata_q;
        byte_c      = dm_dout[7:0];
        half_c      = off_q[1] ? dm_dout[31:16] : dm_dout[15:0];
        load_ext_c  = dm_dout;
        case (off_q)
            2'd0:    byte_c = dm_dout[7:0];
            2'd1:    byte_c = dm_dout[15:8];
            2'd2:    byte_c = dm_dout[23:16];
            default: byte_c = dm_dout[31:24];
        endcase
        case (size_q)
            SZ_BYTE: begin
                lane_mask_c = BW'(4'b0001 << off_q);
                wdata_rep_c = {4{wdata_q[7:0]}};
                load_ext_c  = {{24{~uns_q & byte_c[7]}}, byte_c};
            end
            SZ_HALF: begin
                lane_mask_c = off_q[1] ? 4'b1100 : 4'b0011;
                wdata_rep_c = {2{wdata_q[15:0]}};
                load_ext_c  = {{16{~uns_q & half_c[15]}}, half_c};
            end
            default: begin
                lane_mask_c = 4'b1111;
                wdata_rep_c = wdata_q;
                load_ext_c  = dm_dout;
            end
        endcase
        lane_bits_c = {{8{lane_mask_c[3]}}, {8{lane_mask_c[2]}},
                       {8{lane_mask_c[1]}}, {8{lane_mask_c[0]}}};
        merged_c    = (dm_dout & ~lane_bits_c) | (wdata_rep_c & lane_bits_c);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state, memory strobes and completion decode.
    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        dm_DMWr  = 1'b0;
        dm_BE    = '0;
        dm_din   = '0;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        rdata_nx = rdata;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (req) begin
                    if (bad_c) begin
                        done_nx = 1'b1;
                        err_nx  = 1'b1;
                    end else if (we && (size == SZ_WORD)) begin
                        state_nx = S_WR;
                    end else begin
                        state_nx = S_RD;
                    end
                end
            end
            S_RD: state_nx = we_q ? S_MRG : S_EXT;
            S_EXT: begin
                rdata_nx = load_ext_c;
                done_nx  = 1'b1;
                state_nx = S_IDLE;
            end
            S_MRG: begin
                dm_DMWr  = 1'b1;
                dm_BE    = lane_mask_c;
                dm_din   = merged_c;
                done_nx  = 1'b1;
                state_nx = S_IDLE;
            end
            S_WR: begin
                dm_DMWr  = 1'b1;
                dm_BE    = 4'b1111;
                dm_din   = wdata_q;
                done_nx  = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Request capture and registered completion outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            off_q   <= '0;
            wdata_q <= '0;
            dm_addr <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
        end else begin
            if ((state == S_IDLE) && req) begin
                we_q    <= we;
                size_q  <= size;
                uns_q   <= uns;
                off_q   <= addr[1:0];
                wdata_q <= wdata;
                dm_addr <= AW'(addr[11:2]);
            end
            done  <= done_nx;
            err   <= err_nx;
            rdata <= rdata_nx;
        end
    end

endmodule
